water_level_ctrl_n: RTL and testbench

- Parametrised reservoir level controller with N float sensors.
- Sensor inputs pass through a 2-flop synchroniser and a per-pattern debouncer. The accepted pattern is decoded as a thermometer code into a level 0..N.
- Drives N nominal flow valves plus a supplemental valve (dfr), with hysteresis on fall direction.
- Non-thermometer sensor patterns are flagged as a fault and all flow is shut off.

---
 rtl/water_level_ctrl_n.sv | 118 +++++++++++
 tb/tb_water_level_ctrl_n.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/water_level_ctrl_n.sv
// Reservoir level controller: synchronised, debounced float sensors decoded as a
// thermometer level that drives the nominal and supplemental flow valves.
module water_level_ctrl_n #(
  parameter  int NUM_SENSORS     = 3,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int LVL_W           = $clog2(NUM_SENSORS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] s,
  output logic [NUM_SENSORS-1:0] fr,
  output logic                   dfr,
  output logic [LVL_W-1:0]       level,
  output logic                   rising,
  output logic                   fault,
  output logic                   level_chg
);

  localparam logic [7:0] DB_FULL = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } state_t;

  logic [NUM_SENSORS-1:0] r_sync1;
  logic [NUM_SENSORS-1:0] r_sync2;
  logic [NUM_SENSORS-1:0] r_cand;
  logic [7:0]             r_cnt;

  state_t                 r_state;
  logic [LVL_W-1:0]       r_level;
  logic                   r_rising;
  logic                   r_levelChg;

  logic                   w_accept;
  logic                   w_valid;
  logic [LVL_W-1:0]       w_k;

  function automatic logic [LVL_W-1:0] popcount(input logic [NUM_SENSORS-1:0] v);
    logic [LVL_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      sum = sum + LVL_W'(v[i]);
    end
    return sum;
  endfunction

  // Counter saturates at DEBOUNCE_CYCLES so a steady pattern is accepted exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= s;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= 8'd1;
      end else if (r_cnt < DB_FULL) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign w_accept = (r_sync2 == r_cand) && (r_cnt == DB_LAST);
  // A thermometer code 0..01..1 plus one is a power of two (or wraps to zero).
  assign w_valid  = ((r_cand & (r_cand + NUM_SENSORS'(1))) == '0);
  assign w_k      = popcount(r_cand);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= NORMAL;
      r_level    <= '0;
      r_rising   <= 1'b0;
      r_levelChg <= 1'b0;
    end else begin
      r_levelChg <= 1'b0;
      if (w_accept) begin
        if (!w_valid) begin
          r_state <= FAULT;
        end else begin
          r_state <= NORMAL;
          if (w_k > r_level) begin
            r_level    <= w_k;
            r_rising   <= 1'b1;
            r_levelChg <= 1'b1;
          end else if (w_k < r_level) begin
            r_level    <= w_k;
            r_rising   <= 1'b0;
            r_levelChg <= 1'b1;
          end
        end
      end
    end
  end

  // Valve j closes once the level reaches N-j; dfr adds flow when empty or draining.
  always_comb begin
    fr  = '0;
    dfr = 1'b0;
    if (r_state == NORMAL) begin
      for (int j = 0; j < NUM_SENSORS; j++) begin
        fr[j] = (int'(r_level) < (NUM_SENSORS - j));
      end
      dfr = (r_level == '0) || (!r_rising && (int'(r_level) < NUM_SENSORS));
    end
  end

  assign level     = r_level;
  assign rising    = r_rising;
  assign fault     = (r_state == FAULT);
  assign level_chg = r_levelChg;

endmodule

// File: tb/tb_water_level_ctrl_n.sv
// Directed bench for water_level_ctrl_n (N=3, DEBOUNCE_CYCLES=4) with hand-computed
// expected levels, valve patterns and update timing.
module tb_water_level_ctrl_n;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int LW = $clog2(N + 1);

  logic          clk;
  logic          reset;
  logic [N-1:0]  s;
  logic [N-1:0]  fr;
  logic          dfr;
  logic [LW-1:0] level;
  logic          rising;
  logic          fault;
  logic          level_chg;

  int checkCount;
  int errorCount;
  int chgPulses;

  water_level_ctrl_n #(
    .NUM_SENSORS    (N),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .fr       (fr),
    .dfr      (dfr),
    .level    (level),
    .rising   (rising),
    .fault    (fault),
    .level_chg(level_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance n rising edges, sampling 1ns after each and tallying level_chg pulses.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (level_chg === 1'b1) chgPulses++;
    end
  endtask

  // Apply a pattern and verify the update lands exactly DB+2 edges later.
  task automatic applyStimulus(input string tag, input logic [N-1:0] pat,
                               input int prevLevel, input int expLevel,
                               input logic expRising, input logic [N-1:0] expFr,
                               input logic expDfr);
    s = pat;
    chgPulses = 0;
    tick(DB + 1);
    checkOutput({tag, "_early"}, 32'(level), 32'(prevLevel));
    tick(1);
    checkOutput({tag, "_level"}, 32'(level), 32'(expLevel));
    checkOutput({tag, "_rising"}, 32'(rising), 32'(expRising));
    checkOutput({tag, "_fr"}, 32'(fr), 32'(expFr));
    checkOutput({tag, "_dfr"}, 32'(dfr), 32'(expDfr));
    checkOutput({tag, "_fault"}, 32'(fault), 32'd0);
    checkOutput({tag, "_chg"}, 32'(level_chg), 32'd1);
    tick(4);
    checkOutput({tag, "_pulses"}, 32'(chgPulses), 32'd1);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    chgPulses  = 0;
    reset = 1'b1;
    s     = '0;
    tick(3);
    reset = 1'b0;
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_fr", 32'(fr), 32'b111);
    checkOutput("rst_dfr", 32'(dfr), 32'd1);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_rising", 32'(rising), 32'd0);
    chgPulses = 0;
    tick(10);
    checkOutput("rst_nopulse", 32'(chgPulses), 32'd0);
    checkOutput("rst_hold_fr", 32'(fr), 32'b111);

    applyStimulus("rise1", 3'b001, 0, 1, 1'b1, 3'b011, 1'b0);
    applyStimulus("rise2", 3'b011, 1, 2, 1'b1, 3'b001, 1'b0);
    applyStimulus("rise3", 3'b111, 2, 3, 1'b1, 3'b000, 1'b0);
    applyStimulus("fall2", 3'b011, 3, 2, 1'b0, 3'b001, 1'b1);
    applyStimulus("fall1", 3'b001, 2, 1, 1'b0, 3'b011, 1'b1);

    s = 3'b011;
    chgPulses = 0;
    tick(3);
    s = 3'b001;
    tick(10);
    checkOutput("glitch3_level", 32'(level), 32'd1);
    checkOutput("glitch3_pulses", 32'(chgPulses), 32'd0);

    s = 3'b011;
    tick(4);
    s = 3'b001;
    tick(2);
    checkOutput("glitch4_level", 32'(level), 32'd2);
    checkOutput("glitch4_rising", 32'(rising), 32'd1);
    checkOutput("glitch4_chg", 32'(level_chg), 32'd1);
    s = 3'b011;
    chgPulses = 0;
    tick(10);
    checkOutput("glitch4_hold", 32'(level), 32'd2);
    checkOutput("glitch4_nopulse", 32'(chgPulses), 32'd0);

    s = 3'b101;
    chgPulses = 0;
    tick(DB + 1);
    checkOutput("fault_early", 32'(fault), 32'd0);
    tick(1);
    checkOutput("fault_flag", 32'(fault), 32'd1);
    checkOutput("fault_fr", 32'(fr), 32'b000);
    checkOutput("fault_dfr", 32'(dfr), 32'd0);
    checkOutput("fault_level", 32'(level), 32'd2);
    checkOutput("fault_rising", 32'(rising), 32'd1);
    tick(4);
    checkOutput("fault_nopulse", 32'(chgPulses), 32'd0);
    checkOutput("fault_stay", 32'(fault), 32'd1);

    applyStimulus("recover", 3'b001, 2, 1, 1'b0, 3'b011, 1'b1);

    applyStimulus("refill", 3'b111, 1, 3, 1'b1, 3'b000, 1'b0);
    s = 3'b011;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("midrst_level", 32'(level), 32'd0);
    checkOutput("midrst_fr", 32'(fr), 32'b111);
    checkOutput("midrst_dfr", 32'(dfr), 32'd1);
    checkOutput("midrst_rising", 32'(rising), 32'd0);
    tick(DB + 1);
    checkOutput("midrst_early", 32'(level), 32'd0);
    tick(1);
    checkOutput("midrst_level2", 32'(level), 32'd2);
    checkOutput("midrst_rising2", 32'(rising), 32'd1);
    checkOutput("midrst_fr2", 32'(fr), 32'b001);
    checkOutput("midrst_dfr2", 32'(dfr), 32'd0);
    checkOutput("midrst_chg", 32'(level_chg), 32'd1);
    tick(1);
    checkOutput("midrst_chg_off", 32'(level_chg), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
